// File: rtl/act_ping_pong_buf.sv
// Double-banked activation buffer: a producer layer fills one bank with whole vectors
// while the consumer layer reads the other bank one byte per cycle.
`timescale 1ns/1ps
module act_ping_pong_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 32,
    parameter int BANK_DEPTH = 128,
    parameter int ADDR_W     = 7
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [VEC_LEN*DATA_WIDTH-1:0] wr_vec_i,
    output logic                          full_o,
    output logic                          overflow_o,
    output logic                          ready_o,
    output logic                          start_o,
    input  logic                          rd_en_i,
    input  logic [ADDR_W-1:0]             rd_addr_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    input  logic                          rd_done_i
);

    localparam int NUM_VEC = BANK_DEPTH / VEC_LEN;
    localparam int VEC_AW  = $clog2(VEC_LEN);
    localparam int PTR_W   = ADDR_W - VEC_AW;

    // Each row is one written vector, so the wide write port is a single row store.
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] mem [2][NUM_VEC];

    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_ok;
    logic             wr_last;
    logic             rel;
    logic             handoff;
    logic             ready_p0;
    logic             handoff_p0;

    assign full_o  = full[wr_bank];
    assign ready_o = full[rd_bank];
    assign wr_ok   = wr_en_i && !full_o;
    assign wr_last = (wr_ptr == PTR_W'(NUM_VEC - 1));
    assign rel     = rd_done_i && ready_o;

    always_comb begin
        full_nxt = full;
        if (wr_ok && wr_last) full_nxt[wr_bank] = 1'b1;
        if (rel)              full_nxt[rd_bank] = 1'b0;
    end

    // Release straight onto a bank that is (or becomes) full keeps ready_o high,
    // so the consumer would never see a rising edge without this term.
    assign handoff = rel && full_nxt[~rd_bank];

    always_ff @(posedge clk_i) begin
        if (wr_ok && !rst_i) mem[wr_bank][wr_ptr] <= wr_vec_i;
    end

    // Stage p0: bank bookkeeping, ready/handoff history, registered read port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_ptr     <= '0;
            overflow_o <= 1'b0;
            ready_p0   <= 1'b0;
            handoff_p0 <= 1'b0;
            start_o    <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_ok) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
            if (wr_en_i && full_o) overflow_o <= 1'b1;
            if (rel) rd_bank <= ~rd_bank;
            ready_p0   <= ready_o;
            handoff_p0 <= handoff;
            start_o    <= (ready_o && !ready_p0) || handoff_p0;
            if (rd_en_i)
                rd_data_o <= mem[rd_bank][rd_addr_i[ADDR_W-1:VEC_AW]][rd_addr_i[VEC_AW-1:0]];
        end
    end

endmodule

// File: tb/tb_act_ping_pong_buf.sv
// Directed bench for act_ping_pong_buf: table of per-cycle write/release steps plus
// hand-written read-back, simultaneous-event, spurious-release and reset sequences.
`timescale 1ns/1ps
module tb_act_ping_pong_buf;

    localparam int DW = 8;
    localparam int VL = 32;
    localparam int BD = 128;
    localparam int AW = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [VL*DW-1:0]  wr_vec;
    logic              full;
    logic              overflow;
    logic              ready;
    logic              start;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_done;

    always #5 clk = ~clk;

    act_ping_pong_buf #(
        .DATA_WIDTH(DW), .VEC_LEN(VL), .BANK_DEPTH(BD), .ADDR_W(AW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_vec_i(wr_vec),
        .full_o(full), .overflow_o(overflow), .ready_o(ready), .start_o(start),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_done_i(rd_done)
    );

    typedef struct {
        bit         wr;
        logic [7:0] base;
        bit         done;
        bit         e_full;
        bit         e_ready;
        bit         e_ovf;
        int         e_starts;
    } row_t;

    row_t tbl [14];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   starts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge and start pulses are tallied.
    task automatic tick();
        @(posedge clk);
        #1;
        if (start === 1'b1) starts++;
    endtask

    function automatic logic [VL*DW-1:0] mkvec(input logic [7:0] base, input bit inc);
        logic [VL*DW-1:0] v;
        for (int k = 0; k < VL; k++) v[k*8 +: 8] = inc ? base + 8'(k) : base;
        return v;
    endfunction

    task automatic write_vec(input logic [7:0] base, input bit inc, input bit done);
        wr_en   = 1'b1;
        wr_vec  = mkvec(base, inc);
        rd_done = done;
        tick();
        wr_en   = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic read_one(input int addr, input logic [7:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        tick();
        rd_en   = 1'b0;
        check($sformatf("%s addr%0d", tag, addr), 32'(rd_data), 32'(exp));
    endtask

    task automatic readback(input logic [7:0] off, input bit inc, input string tag);
        for (int a = 0; a < BD; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            tick();
            check($sformatf("%s addr%0d", tag, a), 32'(rd_data),
                  32'(inc ? off + 8'(a) : off));
        end
        rd_en = 1'b0;
    endtask

    task automatic apply_row(input int i);
        wr_en   = tbl[i].wr;
        wr_vec  = mkvec(tbl[i].base, 1'b1);
        rd_done = tbl[i].done;
        tick();
        wr_en   = 1'b0;
        rd_done = 1'b0;
        check($sformatf("row%0d full", i),  32'(full),     32'(tbl[i].e_full));
        check($sformatf("row%0d ready", i), 32'(ready),    32'(tbl[i].e_ready));
        check($sformatf("row%0d ovf", i),   32'(overflow), 32'(tbl[i].e_ovf));
        if (tbl[i].e_starts >= 0)
            check($sformatf("row%0d starts", i), 32'(starts), 32'(tbl[i].e_starts));
    endtask

    initial begin
        // wr, base, done, full, ready, ovf, cumulative start pulses (-1 = not checked)
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[1]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[2]  = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0,  0};
        tbl[3]  = '{1'b1, 8'h60, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1};
        tbl[6]  = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0,  1};
        tbl[7]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0,  1};
        tbl[8]  = '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0,  1};
        tbl[9]  = '{1'b1, 8'hE0, 1'b0, 1'b1, 1'b1, 1'b0,  1};
        tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1,  1};
        tbl[11] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, -1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1,  2};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1,  2};

        rst = 1'b1; wr_en = 1'b0; wr_vec = '0; rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("rst full",  32'(full),     32'd0);
        check("rst ready", 32'(ready),    32'd0);
        check("rst start", 32'(start),    32'd0);
        check("rst ovf",   32'(overflow), 32'd0);
        check("rst rdata", 32'(rd_data),  32'd0);
        starts = 0;

        // Single image into bank 0, then stream it back one byte per cycle
        for (int i = 0; i <= 5; i++) apply_row(i);
        readback(8'h00, 1'b1, "img0");
        tick();
        check("rdata hold", 32'(rd_data), 32'd127);

        // Bank 1 fill, dropped writes, handoff release
        for (int i = 6; i <= 13; i++) apply_row(i);
        read_one(5,   8'h85, "bank1");
        read_one(127, 8'hFF, "bank1");

        // Final bank-0 write and release of bank 1 in the same cycle
        for (int v = 0; v < 3; v++) begin
            write_vec(8'h40 + 8'(v*32), 1'b1, 1'b0);
            check($sformatf("sim wr%0d full", v), 32'(full), 32'd0);
        end
        starts = 0;
        write_vec(8'hA0, 1'b1, 1'b1);
        check("sim ready", 32'(ready), 32'd1);
        check("sim full",  32'(full),  32'd0);
        tick();
        tick();
        tick();
        check("sim starts", 32'(starts), 32'd1);
        read_one(100, 8'hA4, "sim");

        // Legit release, then a spurious one, then a fresh fill of bank 1
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("rel ready", 32'(ready), 32'd0);
        starts = 0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("spur ready", 32'(ready), 32'd0);
        check("spur full",  32'(full),  32'd0);
        for (int v = 0; v < 4; v++) begin
            write_vec(8'(v*32), 1'b1, 1'b0);
            check($sformatf("spur wr%0d ready", v), 32'(ready), 32'(v == 3));
        end
        tick();
        tick();
        check("spur starts", 32'(starts), 32'd1);
        read_one(0,   8'd0,   "spur");
        read_one(64,  8'd64,  "spur");
        read_one(127, 8'd127, "spur");

        // Reset mid-fill with a write still asserted
        write_vec(8'h00, 1'b1, 1'b0);
        write_vec(8'h20, 1'b1, 1'b0);
        rst    = 1'b1;
        wr_en  = 1'b1;
        wr_vec = mkvec(8'h33, 1'b0);
        tick();
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        check("mid rst full",  32'(full),     32'd0);
        check("mid rst ready", 32'(ready),    32'd0);
        check("mid rst start", 32'(start),    32'd0);
        check("mid rst ovf",   32'(overflow), 32'd0);
        check("mid rst rdata", 32'(rd_data),  32'd0);
        for (int v = 0; v < 4; v++) begin
            write_vec(8'h55, 1'b0, 1'b0);
            check($sformatf("refill wr%0d ready", v), 32'(ready), 32'(v == 3));
        end
        readback(8'h55, 1'b0, "refill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
